// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared encodings for the IF/LS RAM port arbiter
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    localparam logic WE_WRITE = 1'b0;
    localparam logic WE_READ  = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rtl/ram_port_arbiter_rr_arb2.sv - two-input round-robin arbiter with enable
module rr_arb2
    import ram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        if (en && !rst) begin
            if (req == 2'b11) begin
                gnt = (last_q == OWN_LS) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end

        // Pointer only moves when a grant is actually issued.
        last_d = last_q;
        if (gnt[OWN_LS]) begin
            last_d = OWN_LS;
        end else if (gnt[OWN_IF]) begin
            last_d = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one single-port RAM between fetch and load/store units
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IF_REQ,
    input  logic [ADDR_SIZE-1:0] IF_ADDR,
    output logic                 IF_GNT,
    output logic                 IF_RVALID,
    output logic [DATA_SIZE-1:0] IF_RDATA,
    input  logic                 LS_REQ,
    input  logic                 LS_WR,
    input  logic [ADDR_SIZE-1:0] LS_ADDR,
    input  logic [DATA_SIZE-1:0] LS_WDATA,
    output logic                 LS_GNT,
    output logic                 LS_DONE,
    output logic [DATA_SIZE-1:0] LS_RDATA,
    output logic                 RAM_WE,
    output logic [ADDR_SIZE-1:0] RAM_ADDRESS,
    output logic [DATA_SIZE-1:0] RAM_DATA_IN,
    input  logic [DATA_SIZE-1:0] RAM_DATA_OUT,
    output logic                 BUSY
);

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0] din_q, din_d;
    logic                 owner_q, owner_d;
    logic                 wr_q, wr_d;
    logic                 if_rvalid_q, if_rvalid_d;
    logic                 ls_done_q, ls_done_d;
    logic [DATA_SIZE-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_SIZE-1:0] ls_rdata_q, ls_rdata_d;

    logic       arb_en;
    logic [1:0] gnt;
    logic       ls_wr_acc;

    assign arb_en = (state_q == ST_IDLE) || (state_q == ST_DONE);

    rr_arb2 u_arb (
        .clk (CLK),
        .rst (RST),
        .en  (arb_en),
        .req ({LS_REQ, IF_REQ}),
        .gnt (gnt)
    );

    assign IF_GNT    = gnt[OWN_IF];
    assign LS_GNT    = gnt[OWN_LS];
    assign ls_wr_acc = gnt[OWN_LS] && LS_WR;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        din_d       = din_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        if_rvalid_d = 1'b0;
        ls_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (|gnt) begin
                    state_d = ST_ACCESS;
                    addr_d  = gnt[OWN_LS] ? LS_ADDR : IF_ADDR;
                    if (ls_wr_acc) begin
                        din_d = LS_WDATA;
                    end
                    // WE drops only here, so it is low for exactly the ACCESS cycle.
                    we_d    = ls_wr_acc ? WE_WRITE : WE_READ;
                    owner_d = gnt[OWN_LS] ? OWN_LS : OWN_IF;
                    wr_d    = ls_wr_acc;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_DONE;
                we_d    = WE_READ;
                if (owner_q == OWN_LS) begin
                    ls_done_d = 1'b1;
                    if (!wr_q) begin
                        ls_rdata_d = RAM_DATA_OUT;
                    end
                end else begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = RAM_DATA_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                we_d    = WE_READ;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            we_q        <= WE_READ;
            addr_q      <= '0;
            din_q       <= '0;
            owner_q     <= OWN_IF;
            wr_q        <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            if_rvalid_q <= if_rvalid_d;
            ls_done_q   <= ls_done_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign RAM_WE      = we_q;
    assign RAM_ADDRESS = addr_q;
    assign RAM_DATA_IN = din_q;
    assign IF_RVALID   = if_rvalid_q;
    assign LS_DONE     = ls_done_q;
    assign IF_RDATA    = if_rdata_q;
    assign LS_RDATA    = ls_rdata_q;
    assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IF_REQ = 1'b0;
    logic [15:0] IF_ADDR = '0;
    logic        IF_GNT, IF_RVALID;
    logic [15:0] IF_RDATA;
    logic        LS_REQ = 1'b0;
    logic        LS_WR = 1'b0;
    logic [15:0] LS_ADDR = '0;
    logic [15:0] LS_WDATA = '0;
    logic        LS_GNT, LS_DONE;
    logic [15:0] LS_RDATA;
    logic        RAM_WE;
    logic [15:0] RAM_ADDRESS, RAM_DATA_IN, RAM_DATA_OUT;
    logic        BUSY;

    ram_port_arbiter #(.DATA_SIZE(16), .ADDR_SIZE(16)) dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT),
        .IF_RVALID(IF_RVALID), .IF_RDATA(IF_RDATA),
        .LS_REQ(LS_REQ), .LS_WR(LS_WR), .LS_ADDR(LS_ADDR), .LS_WDATA(LS_WDATA),
        .LS_GNT(LS_GNT), .LS_DONE(LS_DONE), .LS_RDATA(LS_RDATA),
        .RAM_WE(RAM_WE), .RAM_ADDRESS(RAM_ADDRESS), .RAM_DATA_IN(RAM_DATA_IN),
        .RAM_DATA_OUT(RAM_DATA_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // RAM: asynchronous read, write while WE is low at the clock edge.
    logic [15:0] mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        mem[16'h0010] = 16'hBEEF;
    end
    always @(posedge CLK) if (RAM_WE == 1'b0) mem[RAM_ADDRESS] <= RAM_DATA_IN;
    assign RAM_DATA_OUT = mem[RAM_ADDRESS];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct { bit wr; logic [15:0] addr; logic [15:0] wdata; } cmd_t;
    typedef struct { int cyc; bit rd; logic [15:0] data; } cpl_t;
    typedef struct { int cyc; bit we; logic [15:0] addr; logic [15:0] data; } ram_t;
    typedef struct { bit ls; int cyc; bit busy; } gnt_t;

    cmd_t if_cmds[$], ls_cmds[$];
    cpl_t if_q[$], ls_q[$];
    ram_t ram_q[$];
    gnt_t glog[$];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ls_last = '0;

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        if (a == 16'h0010) return 16'hBEEF;
        return a ^ 16'h5A5A;
    endfunction

    task automatic accept(input bit ls, input cmd_t c);
        glog.push_back('{ls: ls, cyc: cyc, busy: BUSY});
        if (ls && c.wr) begin
            ref_mem[c.addr] = c.wdata;
            ls_q.push_back('{cyc: cyc + 2, rd: 1'b0, data: 16'h0});
            ram_q.push_back('{cyc: cyc + 1, we: 1'b0, addr: c.addr, data: c.wdata});
        end else begin
            if (ls) ls_q.push_back('{cyc: cyc + 2, rd: 1'b1, data: ref_rd(c.addr)});
            else    if_q.push_back('{cyc: cyc + 2, rd: 1'b1, data: ref_rd(c.addr)});
            ram_q.push_back('{cyc: cyc + 1, we: 1'b1, addr: c.addr, data: 16'h0});
        end
    endtask

    task automatic drive_if();
        cmd_t c;
        bit got;
        while (if_cmds.size() > 0) begin
            c = if_cmds.pop_front();
            IF_REQ = 1'b1; IF_ADDR = c.addr;
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge CLK);
                if (IF_GNT) begin got = 1'b1; accept(1'b0, c); end
            end
            if (!got) check("if_gnt_timeout", 0, 1);
            @(posedge CLK); #1;
            IF_REQ = 1'b0;
        end
    endtask

    task automatic drive_ls();
        cmd_t c;
        bit got;
        while (ls_cmds.size() > 0) begin
            c = ls_cmds.pop_front();
            LS_REQ = 1'b1; LS_WR = c.wr; LS_ADDR = c.addr; LS_WDATA = c.wdata;
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge CLK);
                if (LS_GNT) begin got = 1'b1; accept(1'b1, c); end
            end
            if (!got) check("ls_gnt_timeout", 0, 1);
            @(posedge CLK); #1;
            LS_REQ = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge CLK);
            if (!BUSY && if_q.size() == 0 && ls_q.size() == 0 && ram_q.size() == 0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 0, 1);
        @(posedge CLK); #1;
    endtask

    // Monitor: RAM-side cycles, completions, and one-hot grants.
    ram_t r;
    cpl_t e;
    always @(negedge CLK) begin
        if (IF_GNT && LS_GNT) check("gnt_onehot", 2, 1);
        if (ram_q.size() > 0 && ram_q[0].cyc == cyc) begin
            r = ram_q.pop_front();
            check("ram_we", RAM_WE, r.we);
            check("ram_addr", RAM_ADDRESS, r.addr);
            if (!r.we) check("ram_din", RAM_DATA_IN, r.data);
        end else if (RAM_WE == 1'b0) begin
            check("ram_we_stray", RAM_WE, 1);
        end
        if (if_q.size() > 0 && if_q[0].cyc < cyc) begin
            void'(if_q.pop_front());
            check("if_rvalid_missing", 0, 1);
        end
        if (ls_q.size() > 0 && ls_q[0].cyc < cyc) begin
            void'(ls_q.pop_front());
            check("ls_done_missing", 0, 1);
        end
        if (IF_RVALID) begin
            if (if_q.size() == 0) check("if_rvalid_spurious", 1, 0);
            else begin
                e = if_q.pop_front();
                check("if_rvalid_cyc", cyc, e.cyc);
                check("if_rdata", IF_RDATA, e.data);
            end
        end
        if (LS_DONE) begin
            if (ls_q.size() == 0) check("ls_done_spurious", 1, 0);
            else begin
                e = ls_q.pop_front();
                check("ls_done_cyc", cyc, e.cyc);
                if (e.rd) ls_last = e.data;
                check("ls_rdata", LS_RDATA, ls_last);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ram_we", RAM_WE, 1);
        check("rst_ram_addr", RAM_ADDRESS, 0);
        check("rst_ram_din", RAM_DATA_IN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_if_rvalid", IF_RVALID, 0);
        check("rst_ls_done", LS_DONE, 0);
        check("rst_if_rdata", IF_RDATA, 0);
        check("rst_ls_rdata", LS_RDATA, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;

        // Both ports requesting continuously: LS first, then alternate.
        glog.delete();
        if_cmds.push_back('{wr: 1'b0, addr: 16'h0010, wdata: 16'h0});
        if_cmds.push_back('{wr: 1'b0, addr: 16'h0020, wdata: 16'h0});
        if_cmds.push_back('{wr: 1'b0, addr: 16'h0030, wdata: 16'h0});
        ls_cmds.push_back('{wr: 1'b1, addr: 16'h0020, wdata: 16'h7777});
        ls_cmds.push_back('{wr: 1'b0, addr: 16'h0020, wdata: 16'h0});
        ls_cmds.push_back('{wr: 1'b0, addr: 16'h0010, wdata: 16'h0});
        fork
            drive_if();
            drive_ls();
        join
        wait_idle();
        check("rr_count", glog.size(), 6);
        for (int i = 0; i < glog.size(); i++) begin
            check($sformatf("rr_order%0d", i), glog[i].ls, (i % 2 == 0) ? 1 : 0);
            if (i > 0) begin
                check($sformatf("rr_spacing%0d", i), glog[i].cyc - glog[i-1].cyc, 2);
                check($sformatf("rr_busy%0d", i), glog[i].busy, 1);
            end
        end

        // Single fetch of the preloaded word.
        if_cmds.push_back('{wr: 1'b0, addr: 16'h0010, wdata: 16'h0});
        drive_if();
        wait_idle();

        // Write then read back at the top of the address space.
        ls_cmds.push_back('{wr: 1'b1, addr: 16'hFFFF, wdata: 16'h1234});
        ls_cmds.push_back('{wr: 1'b0, addr: 16'hFFFF, wdata: 16'h0});
        drive_ls();
        wait_idle();
        check("ls_rdata_ffff", LS_RDATA, 16'h1234);
        check("ram_addr_ffff", RAM_ADDRESS, 16'hFFFF);

        // LS read with request dropped after grant, then a tie must favour IF.
        ls_cmds.push_back('{wr: 1'b0, addr: 16'h0030, wdata: 16'h0});
        drive_ls();
        wait_idle();
        glog.delete();
        if_cmds.push_back('{wr: 1'b0, addr: 16'h0031, wdata: 16'h0});
        ls_cmds.push_back('{wr: 1'b0, addr: 16'h0032, wdata: 16'h0});
        fork
            drive_if();
            drive_ls();
        join
        wait_idle();
        check("tie_after_ls_count", glog.size(), 2);
        if (glog.size() == 2) begin
            check("tie_after_ls_first", glog[0].ls, 0);
            check("tie_after_ls_second", glog[1].ls, 1);
        end

        // Reset during a write ACCESS: no completion, everything back to reset values.
        LS_REQ = 1'b1; LS_WR = 1'b1; LS_ADDR = 16'h0040; LS_WDATA = 16'hA5A5;
        @(negedge CLK);
        check("rstw_gnt", LS_GNT, 1);
        ram_q.push_back('{cyc: cyc + 1, we: 1'b0, addr: 16'h0040, data: 16'hA5A5});
        ref_mem[16'h0040] = 16'hA5A5;
        @(posedge CLK); #1;
        LS_REQ = 1'b0; RST = 1'b1; IF_REQ = 1'b1; IF_ADDR = 16'h0050;
        @(posedge CLK);
        @(negedge CLK);
        check("rstw_if_gnt", IF_GNT, 0);
        check("rstw_ram_we", RAM_WE, 1);
        check("rstw_busy", BUSY, 0);
        check("rstw_ls_done", LS_DONE, 0);
        check("rstw_if_rdata", IF_RDATA, 0);
        check("rstw_ls_rdata", LS_RDATA, 0);
        ls_last = 16'h0;
        @(posedge CLK); #1;
        RST = 1'b0; IF_REQ = 1'b0;
        repeat (4) @(posedge CLK);
        #1;

        // Pointer is reset too: next tie goes to LS.
        glog.delete();
        if_cmds.push_back('{wr: 1'b0, addr: 16'h0040, wdata: 16'h0});
        ls_cmds.push_back('{wr: 1'b0, addr: 16'h0010, wdata: 16'h0});
        fork
            drive_if();
            drive_ls();
        join
        wait_idle();
        check("tie_after_rst_count", glog.size(), 2);
        if (glog.size() == 2) check("tie_after_rst_first", glog[0].ls, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 16-bit RAM between the instruction-fetch (IF, read-only) and load/store (LS, read/write) units of the CPU.
- Arbitrates round-robin, registers every RAM-side signal, and sequences each access as accept, RAM cycle, completion pulse.
- Guarantees the RAM's level-sensitive write enable (0 = write, 1 = read) is low only during a deliberate, stable write cycle.

Parameters:
- DATA_SIZE, 16, data width of RAM words and all data ports.
- ADDR_SIZE, 16, address width of RAM and all address ports.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- IF_REQ  in  1  fetch request; held with IF_ADDR until IF_GNT.
- IF_ADDR  in  ADDR_SIZE  fetch address.
- IF_GNT  out  1  combinational accept pulse; request sampled at this edge.
- IF_RVALID  out  1  one-cycle pulse; IF_RDATA valid.
- IF_RDATA  out  DATA_SIZE  fetched word; held until next IF read completes.
- LS_REQ  in  1  load/store request; held with LS_WR/LS_ADDR/LS_WDATA until LS_GNT.
- LS_WR  in  1  1 = write, 0 = read.
- LS_ADDR  in  ADDR_SIZE  load/store address.
- LS_WDATA  in  DATA_SIZE  store data.
- LS_GNT  out  1  combinational accept pulse.
- LS_DONE  out  1  one-cycle completion pulse for reads and writes.
- LS_RDATA  out  DATA_SIZE  load data; updated only by reads, otherwise held.
- RAM_WE  out  1  to RAM WE; 0 = write, 1 = read; registered.
- RAM_ADDRESS  out  ADDR_SIZE  to RAM ADDRESS; registered.
- RAM_DATA_IN  out  DATA_SIZE  to RAM DATA_IN; registered.
- RAM_DATA_OUT  in  DATA_SIZE  from RAM DATA_OUT.
- BUSY  out  1  high when state is not IDLE.

Behaviour:
- Reset values:
  - State IDLE; RAM_WE=1; RAM_ADDRESS=0; RAM_DATA_IN=0.
  - IF_RVALID=0, LS_DONE=0; IF_RDATA=0, LS_RDATA=0.
  - Round-robin pointer set so that LS wins the first tie.
- State machine:
  - IDLE: accept if any request is pending, go to ACCESS; otherwise stay.
  - ACCESS: always lasts exactly one cycle, then DONE.
  - DONE: completion pulse is asserted; accept a new request if one is pending and go to ACCESS, otherwise go to IDLE.
- Grant rules:
  - GNT is asserted only in IDLE or DONE, at most one port per cycle, and is forced to 0 while RST=1.
  - On tie, grant the port not granted last; the pointer updates only on a grant.
- On the accept edge:
  - RAM_ADDRESS is loaded from the granted address.
  - RAM_DATA_IN is loaded from LS_WDATA for an LS write; otherwise it holds.
  - RAM_WE is loaded with 0 only for an LS write, otherwise 1.
  - The owner (IF/LS) and read/write flag are latched.
- End of ACCESS:
  - RAM_WE returns to 1.
  - For reads, RAM_DATA_OUT is captured into the owner's RDATA.
  - The owner's RVALID/DONE is registered high for the DONE cycle only.
- Latency: accept at edge N, RAM cycle N to N+1, completion visible during cycle N+1 to N+2. Peak throughput is one access per 2 cycles.
- RAM_ADDRESS and RAM_DATA_IN never change while RAM_WE=0; RAM_WE is never 0 outside ACCESS.
- Address is unsigned and passes through unmodified; 0xFFFF is valid, with no wrap or increment logic.
- A request that drops before GNT is ignored, and no partial state is kept.
- RST in any state, including during a write ACCESS:
  - All registers return to reset values at that edge.
  - No completion pulse is issued for the aborted access; that write may or may not have landed.
  - Requesters must re-issue.
- Simultaneous IF_REQ and LS_REQ in DONE are arbitrated identically to IDLE.

Decomposition:
- Shared package holds:
  - State encoding: ST_IDLE=2'b00, ST_ACCESS=2'b01, ST_DONE=2'b10.
  - Owner ids: OWN_IF=1'b0, OWN_LS=1'b1.
  - RAM enable encoding: WE_WRITE=1'b0, WE_READ=1'b1.
- One sub-module, rr_arb2: two-input round-robin arbiter with an enable input, a pointer register, and one-hot grant outputs.

Test Plan:
- IF_REQ, IF_ADDR=0x0010, RAM[0x0010]=0xBEEF -> IF_GNT pulse at N; RAM_WE=1 throughout; IF_RVALID high for the one cycle after the ACCESS cycle; IF_RDATA=0xBEEF.
- LS write 0x1234 to 0xFFFF, then LS read of 0xFFFF -> RAM_WE=0 for exactly one cycle with stable address and data; LS_DONE pulses twice; LS_RDATA=0x1234 after the read; no overflow at 0xFFFF.
- IF and LS both requesting continuously for 6 grants -> grant order LS, IF, LS, IF, LS, IF; one accept every 2 cycles; BUSY stays high.
- Requests from DONE back-to-back -> next access starts without returning to IDLE; no cycle has RAM_WE=0 outside ACCESS.
- RST asserted during a write ACCESS -> next cycle RAM_WE=1, state IDLE, no LS_DONE pulse, RDATA registers 0.
- LS read accepted, then LS_REQ dropped before any further grant -> exactly one LS_DONE; pointer favours IF on the next tie.
